// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults and types for the 1-to-2 buffered byte demux.
//   WIDTH_DEF - default data width
//   DEPTH_DEF - default entries per output FIFO (power of two, >= 2)
//   CNT_W_DEF - default width of the delivered-byte counters
//   chan_t    - output channel index (0 or 1)
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 8;

  typedef logic chan_t;

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: one output channel of the demux. A small FIFO with a
// valid/ready read side and a counter of bytes popped from it.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   push_i        - write data_i this cycle (ignored when full)
//   data_i        - byte to write
//   ready_i       - consumer takes the head this cycle
//   data_o        - head entry, 0 when empty
//   valid_o       - FIFO non-empty
//   full_o        - FIFO full
//   count_o       - bytes popped, wraps modulo 2^CNT_W
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty;
  logic push_ok;
  logic pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = !empty && ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok) begin
      rptr_d  = rptr_q + PW'(1);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks its head to 0 below.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign valid_o = !empty;
  assign count_o = count_q;

endmodule

// File: rtl/demux_1to2_8_buf.sv
// demux_1to2_8_buf: steers each accepted input byte to one of two buffered
// output channels chosen by select, and counts bytes delivered per channel.
//   Clk, Reset_n                 - clock, asynchronous active-low reset
//   Din, Din_valid, Din_ready    - input stream handshake
//   select                       - destination channel for Din
//   Dout0/1, Dout0/1_valid/ready - output channel handshakes
//   Count0, Count1               - bytes popped from each channel
module demux_1to2_8_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  input  chan_t            select,
  output logic             Din_ready,
  output logic [WIDTH-1:0] Dout0,
  output logic             Dout0_valid,
  input  logic             Dout0_ready,
  output logic [WIDTH-1:0] Dout1,
  output logic             Dout1_valid,
  input  logic             Dout1_ready,
  output logic [CNT_W-1:0] Count0,
  output logic [CNT_W-1:0] Count1
);

  // Holds Din_ready low during reset and until the first edge after release.
  logic run_q;
  logic run_d;

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  assign run_d = 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) run_q <= 1'b0;
    else          run_q <= run_d;
  end

  // Ready depends only on the selected FIFO's current fullness; a same-cycle
  // pop on a full channel does not open a slot for this cycle's push.
  assign Din_ready = run_q && !((select == 1'b1) ? full1 : full0);

  assign push0 = Din_valid && Din_ready && (select == 1'b0);
  assign push1 = Din_valid && Din_ready && (select == 1'b1);

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo0 (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push0),
    .data_i  (Din),
    .ready_i (Dout0_ready),
    .data_o  (Dout0),
    .valid_o (Dout0_valid),
    .full_o  (full0),
    .count_o (Count0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push1),
    .data_i  (Din),
    .ready_i (Dout1_ready),
    .data_o  (Dout1),
    .valid_o (Dout1_valid),
    .full_o  (full1),
    .count_o (Count1)
  );

endmodule

// File: tb/tb_demux_1to2_8_buf.sv
// tb_demux_1to2_8_buf: directed, table-driven bench for demux_1to2_8_buf.
// Inputs change 1 ns after a rising edge; outputs are sampled mid-cycle.
module tb_demux_1to2_8_buf;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] Din;
  logic       Din_valid;
  logic       select;
  logic       Din_ready;
  logic [7:0] Dout0;
  logic       Dout0_valid;
  logic       Dout0_ready;
  logic [7:0] Dout1;
  logic       Dout1_valid;
  logic       Dout1_ready;
  logic [7:0] Count0;
  logic [7:0] Count1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  demux_1to2_8_buf dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .select      (select),
    .Din_ready   (Din_ready),
    .Dout0       (Dout0),
    .Dout0_valid (Dout0_valid),
    .Dout0_ready (Dout0_ready),
    .Dout1       (Dout1),
    .Dout1_valid (Dout1_valid),
    .Dout1_ready (Dout1_ready),
    .Count0      (Count0),
    .Count1      (Count1)
  );

  // Inputs for one cycle plus the outputs expected before that cycle's edge.
  typedef struct packed {
    logic [7:0] din;
    logic       vld;
    logic       sel;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic s,
                       input logic r0, input logic r1);
    Din         = d;
    Din_valid   = v;
    select      = s;
    Dout0_ready = r0;
    Dout1_ready = r1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rdy"},  {31'd0, Din_ready},   32'd0);
    chk({tag, " v0"},   {31'd0, Dout0_valid}, 32'd0);
    chk({tag, " v1"},   {31'd0, Dout1_valid}, 32'd0);
    chk({tag, " d0"},   {24'd0, Dout0},       32'd0);
    chk({tag, " d1"},   {24'd0, Dout1},       32'd0);
    chk({tag, " c0"},   {24'd0, Count0},      32'd0);
    chk({tag, " c1"},   {24'd0, Count1},      32'd0);
  endtask

  initial begin
    //            din    vld   sel   r0    r1    rdy   v0    d0     v1    d1     c0    c1
    tbl[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[2]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd1, 8'd0};
    tbl[3]  = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd1, 8'd0};
    tbl[4]  = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 8'd1, 8'd0};
    tbl[5]  = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd1, 8'd0};
    tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h33, 8'd1, 8'd0};
    tbl[7]  = '{8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h33, 8'd1, 8'd0};
    tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 8'h33, 8'd2, 8'd0};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 8'd2, 8'd1};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 8'd2, 8'd1};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd3, 8'd1};

    // Reset state, then release between edges: ready must wait for an edge.
    Reset_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all_zero("reset");
    Reset_n = 1'b1;
    #1;
    chk("release rdy", {31'd0, Din_ready}, 32'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].din, tbl[i].vld, tbl[i].sel, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("v%0d rdy", i), {31'd0, Din_ready},   {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d v0", i),  {31'd0, Dout0_valid}, {31'd0, tbl[i].e_v0});
      chk($sformatf("v%0d d0", i),  {24'd0, Dout0},       {24'd0, tbl[i].e_d0});
      chk($sformatf("v%0d v1", i),  {31'd0, Dout1_valid}, {31'd0, tbl[i].e_v1});
      chk($sformatf("v%0d d1", i),  {24'd0, Dout1},       {24'd0, tbl[i].e_d1});
      chk($sformatf("v%0d c0", i),  {24'd0, Count0},      {24'd0, tbl[i].e_c0});
      chk($sformatf("v%0d c1", i),  {24'd0, Count1},      {24'd0, tbl[i].e_c1});
      tick();
    end

    // Mid-stream reset with both channels holding data.
    drive(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre-rst d0", {23'd0, Dout0_valid, Dout0}, {23'd0, 1'b1, 8'h5A});
    chk("pre-rst d1", {23'd0, Dout1_valid, Dout1}, {23'd0, 1'b1, 8'h6B});
    chk("pre-rst c0", {24'd0, Count0}, 32'd3);
    Reset_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post-rst rdy", {31'd0, Din_ready}, 32'd1);

    // Streaming on channel 1: 00..09 back-to-back, one-cycle latency.
    for (int i = 0; i <= 10; i++) begin
      drive(8'(i), (i < 10), 1'b1, 1'b1, 1'b1);
      #1;
      if (i >= 1) begin
        chk($sformatf("stream%0d d1", i), {23'd0, Dout1_valid, Dout1}, {23'd0, 1'b1, 8'(i - 1)});
      end
      chk($sformatf("stream%0d v0", i), {31'd0, Dout0_valid}, 32'd0);
      tick();
    end
    chk("stream c1", {24'd0, Count1}, 32'd10);
    chk("stream c0", {24'd0, Count0}, 32'd0);

    // Channel 0 counter wrap: 257 pushes, each popped on the following edge.
    for (int i = 0; i <= 257; i++) begin
      drive(8'(i), (i < 257), 1'b0, 1'b1, 1'b0);
      #1;
      if (i == 1 || i == 128 || i == 256) begin
        chk($sformatf("wrap%0d d0", i), {23'd0, Dout0_valid, Dout0}, {23'd0, 1'b1, 8'(i - 1)});
      end
      tick();
      if (i == 255) chk("wrap c0 255", {24'd0, Count0}, 32'd255);
      if (i == 256) chk("wrap c0 0",   {24'd0, Count0}, 32'd0);
      if (i == 257) chk("wrap c0 1",   {24'd0, Count0}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_1to2_8_buf.md
Name: demux_1to2_8_buf

Overview:
Sequential counterpart to the 8-bit 2:1 select path. It takes one 8-bit input stream with a valid/ready handshake and steers each accepted byte to one of two output channels, chosen by select. Each output channel has its own small FIFO and its own valid/ready handshake. The block sits between a single data producer (for example the shift/load datapath) and two independent consumers, and it counts the bytes delivered on each channel.

Parameters:
WIDTH, 8, data width of Din, Dout0 and Dout1
DEPTH, 2, entries per output FIFO; must be a power of two and >= 2
CNT_W, 8, width of each delivered-byte counter

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Din  input  WIDTH  input byte
Din_valid  input  1  Din is presented
select  input  1  destination channel for Din: 0 = channel 0, 1 = channel 1
Din_ready  output  1  block can accept Din this cycle
Dout0  output  WIDTH  head entry of FIFO 0
Dout0_valid  output  1  FIFO 0 is non-empty
Dout0_ready  input  1  consumer 0 takes Dout0
Dout1  output  WIDTH  head entry of FIFO 1
Dout1_valid  output  1  FIFO 1 is non-empty
Dout1_ready  input  1  consumer 1 takes Dout1
Count0  output  CNT_W  bytes popped from channel 0
Count1  output  CNT_W  bytes popped from channel 1

Behaviour:
- Reset: one clock; Reset_n is asynchronous and active-low.
  - While Reset_n = 0: both FIFOs are empty; Dout0_valid = Dout1_valid = 0; Dout0 = Dout1 = 0; Count0 = Count1 = 0.
  - Din_ready = 0 while Reset_n is low and is 1 from the first edge after release.
  - Reset asserted mid-operation discards all buffered bytes immediately.
- Din_ready = NOT full(FIFO[select]). It is combinational from select and the FIFO state only, never from Din_valid.
- Push: Din_valid & Din_ready at a rising edge writes Din into FIFO[select].
  - No byte is ever written to the unselected channel.
- Pop k: Doutk_valid & Doutk_ready at a rising edge removes the head of FIFO k and increments Countk modulo 2^CNT_W.
  - Count wraps from 2^CNT_W-1 to 0.
- Latency: a byte pushed at edge N appears on Doutk with Doutk_valid = 1 after edge N, when FIFO k was empty.
  - There is no combinational path from Din to Doutk.
- Doutk = head entry when non-empty, and 0 when empty.
- Doutk and Doutk_valid hold steady while Doutk_ready = 0.
- Push and pop on the same channel in the same cycle: occupancy unchanged, order preserved.
- Full channel: Din_ready = 0 when select points at it.
  - A pop on that channel in the same cycle does NOT enable a push; there is no bypass, and Din_ready rises the cycle after the pop.
- The other channel is independent. With select pointing at a non-full channel, Din_ready = 1 even if the other channel is full.
- Ordering: each channel is strictly FIFO. Bytes on different channels have no ordering relation.
- select changing while Din_valid = 1 and Din_ready = 0 is legal. Din_ready re-evaluates for the new channel.
- Din, select and Din_valid are ignored when Din_ready = 0.
- Pointers: read and write pointers are log2(DEPTH)+1 bits wide.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Pointers wrap naturally.

Decomposition:
- Package demux_pkg: WIDTH default, DEPTH default, CNT_W default, and a channel-index typedef (logic, 1 bit).
- Sub-module demux_fifo: one FIFO with push/pop, full/empty, head output and delivered-byte counter.
  - Instantiated twice.
  - The top level holds only the steering logic, the Din_ready mux and the push-enable decode.

Test Plan:
- Reset release, Din = 8'hA5, select = 0, valid for 1 cycle -> Dout0 = 8'hA5, Dout0_valid = 1 one cycle later; Dout1_valid stays 0; Count0 = 1 after pop with Dout0_ready = 1.
- Dout0_ready = 0; push 8'h11, 8'h22 to channel 0; present 8'h33 with select = 0 -> Din_ready = 0 and 8'h33 is not accepted. Switch select = 1 -> Din_ready = 1; 8'h33 appears on Dout1; Dout0 holds 8'h11.
- FIFO 0 full; assert Dout0_ready with Din_valid = 1, select = 0 in the same cycle -> Dout0 advances to 8'h22; no push that cycle; Din_ready = 1 the next cycle.
- Continuous push and pop on channel 1 with both readies = 1 for 10 bytes 8'h00..8'h09 -> output order 00..09 with 1-cycle latency; Count1 = 10; Count0 = 0.
- 256 pops on channel 0 (CNT_W = 8) -> Count0 wraps to 0; the 257th pop gives 1.
- Assert Reset_n = 0 mid-stream with both FIFOs holding data -> Dout0_valid = Dout1_valid = 0, Dout0 = Dout1 = 0, counts = 0 and Din_ready = 0 immediately, without waiting for a clock edge.
